// File: rtl/outarb.sv
// outarb: switch arbiter for one output physical channel of the router.
// Collects requests from the five input controllers, grants this output to
// one of them for a whole packet (head to tail), and rotates priority
// round-robin between packets. The grant goes back to the input controllers
// and the owner index drives the crossbar select for this output.
module outarb #(
  parameter int ROUTERID = 0,
  parameter int PORTID   = 0,
  parameter int PORTW    = 2
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           req_0,
  input  logic           req_1,
  input  logic           req_2,
  input  logic           req_3,
  input  logic           req_4,
  input  logic [PORTW:0] port_0,
  input  logic [PORTW:0] port_1,
  input  logic [PORTW:0] port_2,
  input  logic [PORTW:0] port_3,
  input  logic [PORTW:0] port_4,
  input  logic           tail_0,
  input  logic           tail_1,
  input  logic           tail_2,
  input  logic           tail_3,
  input  logic           tail_4,
  input  logic           ordy,
  output logic           grt_0,
  output logic           grt_1,
  output logic           grt_2,
  output logic           grt_3,
  output logic           grt_4,
  output logic [PORTW:0] sel,
  output logic           busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arbState_t;

  localparam logic [PORTW:0] PortMatch = (PORTW + 1)'(PORTID);

  // Reject parameter sets the five-input owner encoding cannot represent.
  if (PORTID < 0 || PORTID > 4 || PORTW < 2 || ROUTERID < 0) begin : gBadParams
    $error("outarb: invalid parameter set");
  end

  arbState_t      state_q, state_d;
  logic [2:0]     owner_q, owner_d;
  logic [2:0]     rr_q, rr_d;
  logic [PORTW:0] sel_q, sel_d;
  logic           busy_q, busy_d;

  logic [4:0]     reqVec;
  logic [4:0]     tailVec;
  logic [PORTW:0] portVec [5];
  logic [4:0]     candVec;
  logic [4:0]     grtVec;

  logic [2:0]     rrBase;
  logic [2:0]     scanIdx;
  logic [2:0]     pick;
  logic           found;

  logic           ownerReq;
  logic           ownerTail;
  logic           ownerGrant;
  logic           releaseLock;
  logic [2:0]     nextRr;

  // Fold an index in 0..8 back into 0..4.
  function automatic logic [2:0] wrapIdx(input logic [3:0] v);
    if (v >= 4'd5) begin
      return 3'(v - 4'd5);
    end
    return v[2:0];
  endfunction

  // Gather the per-input ports into vectors so the arbiter can loop over them.
  always_comb begin
    reqVec     = {req_4, req_3, req_2, req_1, req_0};
    tailVec    = {tail_4, tail_3, tail_2, tail_1, tail_0};
    portVec[0] = port_0;
    portVec[1] = port_1;
    portVec[2] = port_2;
    portVec[3] = port_3;
    portVec[4] = port_4;
  end

  // An input is a candidate only when it requests and its route targets this output.
  always_comb begin
    candVec = '0;
    for (int i = 0; i < 5; i++) begin
      candVec[i] = reqVec[i] && (portVec[i] == PortMatch);
    end
  end

  // Round-robin scan starting at the pointer; a corrupted pointer restarts at input 0.
  always_comb begin
    rrBase  = (rr_q > 3'd4) ? 3'd0 : rr_q;
    found   = 1'b0;
    pick    = 3'd0;
    scanIdx = 3'd0;
    for (int k = 0; k < 5; k++) begin
      scanIdx = wrapIdx({1'b0, rrBase} + 4'(k));
      if (!found && candVec[scanIdx]) begin
        found = 1'b1;
        pick  = scanIdx;
      end
    end
  end

  // Owner-side view: grant whenever downstream has room, release on a granted
  // tail or when the owner abandons the packet by dropping its request.
  always_comb begin
    ownerReq    = reqVec[owner_q];
    ownerTail   = tailVec[owner_q];
    ownerGrant  = (state_q == BUSY) && ordy && ownerReq;
    releaseLock = (state_q == BUSY) && ((ownerGrant && ownerTail) || !ownerReq);
    nextRr      = (owner_q >= 3'd4) ? 3'd0 : owner_q + 3'd1;
  end

  // The grant is combinational so a stalled downstream stops flits in the same cycle.
  always_comb begin
    grtVec = '0;
    if (ownerGrant) begin
      grtVec[owner_q] = 1'b1;
    end
  end

  // Next-state logic: lock onto a winner when idle, unlock and advance priority on release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          owner_d = pick;
          sel_d   = (PORTW + 1)'(pick);
          busy_d  = 1'b1;
        end
      end
      BUSY: begin
        if (releaseLock) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          rr_d    = nextRr;
        end
      end
    endcase
  end

  // State and registered outputs; reset aborts any lock and clears priority at once.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= IDLE;
      owner_q <= 3'd0;
      rr_q    <= 3'd0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grtVec;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule
